// File: rtl/datapath_issue_ctrl.sv
// ---------------------------------------------------------------------------
// datapath_issue_ctrl
//
// Sequencing controller for the mini CPU datapath. It accepts one instruction
// at a time, reads operands from a small register file and presents A/B/Op to
// datapath_core through registers. It captures the result and flags, writes
// the result back and returns a response.
// Flow: IDLE (accept) -> EXEC (datapath settles, writeback) -> RESP (hold
// response until consumed) -> IDLE.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          instruction handshake (ready only in IDLE)
//   in_op, in_rd, in_rs1,
//   in_rs2, in_imm, in_use_imm instruction fields
//   dp_a, dp_b, dp_op          registered operands/opcode to datapath_core
//   dp_result, dp_zero, dp_neg,
//   dp_carry, dp_overflow      combinational result/flags from datapath_core
//   out_valid/out_ready        response handshake
//   out_result, out_flags,
//   out_err                    response payload ({Z,N,C,V} flags)
//   dbg_addr, dbg_data         combinational register-file debug read port
// ---------------------------------------------------------------------------
module datapath_issue_ctrl #(
    parameter int WIDTH  = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic              in_use_imm,
    output logic [WIDTH-1:0]  dp_a,
    output logic [WIDTH-1:0]  dp_b,
    output logic [3:0]        dp_op,
    input  logic [WIDTH-1:0]  dp_result,
    input  logic              dp_zero,
    input  logic              dp_neg,
    input  logic              dp_carry,
    input  logic              dp_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [3:0]        out_flags,
    output logic              out_err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int NREGS = 2 ** REG_AW;
    localparam logic [3:0] OP_LDI = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   dp_a_q, dp_a_d;
    logic [WIDTH-1:0]   dp_b_q, dp_b_d;
    logic [3:0]         dp_op_q, dp_op_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic [3:0]         out_flags_q, out_flags_d;
    logic               out_valid_q, out_valid_d;
    logic               out_err_q, out_err_d;

    logic [WIDTH-1:0]   rs1_val, rs2_val;
    logic [WIDTH-1:0]   wb_val;
    logic [3:0]         wb_flags;
    logic               op_is_alu, op_is_ldi;

    // r0 is hard-wired to zero on every read port.
    assign rs1_val  = (in_rs1 == '0) ? '0 : regs_q[in_rs1];
    assign rs2_val  = (in_rs2 == '0) ? '0 : regs_q[in_rs2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

    // Opcodes 0000-0111 go through the datapath; 1000 is LDI; the rest are illegal.
    assign op_is_alu = ~op_q[3];
    assign op_is_ldi = (op_q == OP_LDI);

    always_comb begin
        wb_val   = '0;
        wb_flags = flags_q;
        if (op_is_alu) begin
            wb_val   = dp_result;
            wb_flags = {dp_zero, dp_neg, dp_carry, dp_overflow};
        end else if (op_is_ldi) begin
            wb_val   = imm_q;
            wb_flags = {(imm_q == '0), imm_q[WIDTH-1], 1'b0, 1'b0};
        end
    end

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        flags_d      = flags_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        dp_op_d      = dp_op_q;
        rd_d         = rd_q;
        op_d         = op_q;
        imm_d        = imm_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_valid_d  = out_valid_q;
        out_err_d    = out_err_q;
        in_ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dp_a_d  = rs1_val;
                    dp_b_d  = in_use_imm ? in_imm : rs2_val;
                    // LDI and illegal opcodes still present a benign ADD to the datapath.
                    dp_op_d = in_op[3] ? 4'b0000 : in_op;
                    rd_d    = in_rd;
                    op_d    = in_op;
                    imm_d   = in_imm;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_is_alu || op_is_ldi) begin
                    if (rd_q != '0) begin
                        regs_d[rd_q] = wb_val;
                    end
                    flags_d   = wb_flags;
                    out_err_d = 1'b0;
                end else begin
                    out_err_d = 1'b1;
                end
                out_result_d = wb_val;
                out_flags_d  = wb_flags;
                out_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q      <= '0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_op_q      <= '0;
            rd_q         <= '0;
            op_q         <= '0;
            imm_q        <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q      <= flags_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            dp_op_q      <= dp_op_d;
            rd_q         <= rd_d;
            op_q         <= op_d;
            imm_q        <= imm_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_valid_q  <= out_valid_d;
            out_err_q    <= out_err_d;
        end
    end

    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_op      = dp_op_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_datapath_issue_ctrl.sv
// Bench for datapath_issue_ctrl. A behavioural stand-in for datapath_core
// answers dp_a/dp_b/dp_op combinationally.
module tb_datapath_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op = '0;
    logic [1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [7:0] in_imm = '0;
    logic       in_use_imm = 1'b0;
    logic [7:0] dp_a, dp_b;
    logic [3:0] dp_op;
    logic [7:0] dp_result;
    logic       dp_zero, dp_neg, dp_carry, dp_overflow;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic       out_err;
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_issue_ctrl #(.WIDTH(8), .REG_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
        .dp_result(dp_result), .dp_zero(dp_zero), .dp_neg(dp_neg),
        .dp_carry(dp_carry), .dp_overflow(dp_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Datapath behaviour: returns {result, Z, N, C, V}. C is carry-out for ADD, borrow for SUB.
    function automatic logic [11:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        logic [7:0] r;
        logic c, v;
        r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255);
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            4'd6: r = a << b[2:0];
            4'd7: r = a >> b[2:0];
            default: r = 8'h00;
        endcase
        return {r, (r == 8'h00), r[7], c, v};
    endfunction

    always_comb begin
        {dp_result, dp_zero, dp_neg, dp_carry, dp_overflow} = alu(dp_op, dp_a, dp_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference architectural state.
    logic [7:0] mregs [4];
    logic [3:0] mflags;

    // Issues one instruction, holds out_ready low for 'delay' cycles of RESP, then consumes.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm, input logic ui, input int delay,
                         output logic [7:0] a, output logic [7:0] b, output logic [3:0] dop,
                         output logic [7:0] res, output logic [3:0] fl, output logic err);
        int n;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = ui;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("exec_out_valid", 32'(out_valid), 32'd0);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        a = dp_a; b = dp_b; dop = dp_op;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("resp_timeout", 32'(n < 20), 32'd1);
        repeat (delay) @(negedge clk);
        res = out_result; fl = out_flags; err = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("resp_drop", 32'(out_valid), 32'd0);
        chk("resp_err_clear", 32'(out_err), 32'd0);
    endtask

    typedef struct {
        logic [3:0] op; logic [1:0] rd, rs1, rs2; logic [7:0] imm; logic ui;
        logic [7:0] ea, eb; logic [3:0] edop;
        logic [7:0] eres; logic [3:0] efl; logic eerr;
        logic [1:0] daddr; logic [7:0] edbg;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [7:0] a, b, res, ea, eb, eres;
        logic [3:0] dop, fl, edop, efl;
        logic err, eerr;
        logic [11:0] alu_out;
        logic [7:0] held;

        //           op     rd rs1 rs2 imm    ui  ea     eb     edop   eres   efl     eerr dadr edbg
        vt[0] = '{4'd8,  1, 0, 0, 8'h05, 1, 8'h00, 8'h05, 4'd0, 8'h05, 4'b0000, 0, 1, 8'h05};
        vt[1] = '{4'd8,  2, 0, 0, 8'h03, 1, 8'h00, 8'h03, 4'd0, 8'h03, 4'b0000, 0, 2, 8'h03};
        vt[2] = '{4'd0,  3, 1, 2, 8'h00, 0, 8'h05, 8'h03, 4'd0, 8'h08, 4'b0000, 0, 3, 8'h08};
        vt[3] = '{4'd1,  3, 1, 1, 8'h00, 0, 8'h05, 8'h05, 4'd1, 8'h00, 4'b1000, 0, 3, 8'h00};
        vt[4] = '{4'd8,  1, 0, 0, 8'h80, 1, 8'h00, 8'h80, 4'd0, 8'h80, 4'b0100, 0, 1, 8'h80};
        vt[5] = '{4'd8,  1, 0, 0, 8'h01, 1, 8'h00, 8'h01, 4'd0, 8'h01, 4'b0000, 0, 1, 8'h01};
        vt[6] = '{4'd0,  1, 1, 0, 8'hFF, 1, 8'h01, 8'hFF, 4'd0, 8'h00, 4'b1010, 0, 1, 8'h00};
        vt[7] = '{4'd10, 2, 3, 2, 8'h00, 0, 8'h00, 8'h03, 4'd0, 8'h00, 4'b1010, 1, 2, 8'h03};
        vt[8] = '{4'd8,  0, 0, 0, 8'hAA, 1, 8'h00, 8'hAA, 4'd0, 8'hAA, 4'b0100, 0, 0, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_dp_a", 32'(dp_a), 32'd0);
        chk("rst_dp_b", 32'(dp_b), 32'd0);
        chk("rst_dp_op", 32'(dp_op), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r); #1;
            chk("rst_reg", 32'(dbg_data), 32'd0);
        end

        // Directed table
        for (int i = 0; i < 9; i++) begin
            issue(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].ui, i % 3,
                  a, b, dop, res, fl, err);
            chk($sformatf("v%0d_dp_a", i), 32'(a), 32'(vt[i].ea));
            chk($sformatf("v%0d_dp_b", i), 32'(b), 32'(vt[i].eb));
            chk($sformatf("v%0d_dp_op", i), 32'(dop), 32'(vt[i].edop));
            chk($sformatf("v%0d_result", i), 32'(res), 32'(vt[i].eres));
            chk($sformatf("v%0d_flags", i), 32'(fl), 32'(vt[i].efl));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].eerr));
            dbg_addr = vt[i].daddr; #1;
            chk($sformatf("v%0d_dbg", i), 32'(dbg_data), 32'(vt[i].edbg));
        end
        mregs[0] = 8'h00; mregs[1] = 8'h00; mregs[2] = 8'h03; mregs[3] = 8'h00;
        mflags = 4'b0100;
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r); #1;
            chk("table_final_reg", 32'(dbg_data), 32'(mregs[r]));
        end

        // Back-pressure in RESP with a stray in_valid pulse
        @(negedge clk);
        in_op = 4'd8; in_rd = 2'd2; in_rs1 = 2'd0; in_rs2 = 2'd0; in_imm = 8'h55; in_use_imm = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        held = out_result;
        chk("bp_result", 32'(held), 32'h55);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_op = 4'd8; in_rd = 2'd3; in_imm = 8'h77; in_use_imm = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", 32'(out_result), 32'h55);
            chk("bp_hold_flags", 32'(out_flags), 32'b0000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_pulse_not_taken", 32'(out_valid), 32'd0);
        mregs[2] = 8'h55; mflags = 4'b0000;
        dbg_addr = 2'd3; #1;
        chk("bp_r3_untouched", 32'(dbg_data), 32'(mregs[3]));
        dbg_addr = 2'd2; #1;
        chk("bp_r2_written", 32'(dbg_data), 32'h55);

        // Reset while in EXEC abandons the instruction
        @(negedge clk);
        in_op = 4'd8; in_rd = 2'd1; in_imm = 8'h33; in_use_imm = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_exec_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_exec_in_ready", 32'(in_ready), 32'd1);
        chk("rst_exec_flags", 32'(out_flags), 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r); #1;
            chk("rst_exec_reg", 32'(dbg_data), 32'd0);
            mregs[r] = 8'h00;
        end
        mflags = 4'b0000;

        // Randomized instructions against the architectural model
        for (int t = 0; t < 300; t++) begin
            logic [3:0] op;
            logic [1:0] rd, rs1, rs2;
            logic [7:0] imm;
            logic ui;
            op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            rd  = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
            imm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ui  = 1'($urandom);

            ea = mregs[rs1];
            eb = ui ? imm : mregs[rs2];
            edop = op[3] ? 4'd0 : op;
            eerr = 1'b0;
            if (op < 4'd8) begin
                alu_out = alu(op, ea, eb);
                eres = alu_out[11:4]; efl = alu_out[3:0];
            end else if (op == 4'd8) begin
                eres = imm; efl = {(imm == 8'h00), imm[7], 2'b00};
            end else begin
                eres = 8'h00; efl = mflags; eerr = 1'b1;
            end
            if (!eerr) begin
                mflags = efl;
                if (rd != 2'd0) mregs[rd] = eres;
            end

            issue(op, rd, rs1, rs2, imm, ui, $urandom_range(0, 2), a, b, dop, res, fl, err);
            chk("rnd_dp_a", 32'(a), 32'(ea));
            chk("rnd_dp_b", 32'(b), 32'(eb));
            chk("rnd_dp_op", 32'(dop), 32'(edop));
            chk("rnd_result", 32'(res), 32'(eres));
            chk("rnd_flags", 32'(fl), 32'(efl));
            chk("rnd_err", 32'(err), 32'(eerr));
            dbg_addr = 2'($urandom); #1;
            chk("rnd_dbg", 32'(dbg_data), 32'(mregs[dbg_addr]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
